// File: rtl/sd_fetch_pkg.sv
// Shared types and constants for the SD block fetcher.
package sd_fetch_pkg;

  localparam int unsigned BLK_BYTES_DEF = 512;
  localparam int unsigned BLK_AW        = $clog2(BLK_BYTES_DEF);

  // Legacy state encodings, kept stable for existing debug tooling.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_INIT = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_FILL      = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_INIT = ST_WAIT_INIT,
    REQ       = ST_REQ,
    FILL      = ST_FILL,
    READY     = ST_READY
  } fetch_state_t;

  // SD block number for run offset idx; wraps at 2^32.
  function automatic logic [31:0] blk_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + 32'(idx);
  endfunction

endpackage

// File: rtl/sd_buf_ram.sv
// Simple dual-port block buffer: one write port, one registered read port.
module sd_buf_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_block_fetch.sv
// Fetches a run of consecutive SD blocks into a buffer and hands each to the application.
// Optional BLK_CHECKSUM_EN adds a per-block mod-2^16 byte sum output (blk_sum).
module sd_block_fetch
  import sd_fetch_pkg::*;
#(
  parameter int unsigned BLK_BYTES   = BLK_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [31:0]                  start_blk,
  input  logic [15:0]                  num_blks,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  input  logic                         sd_init_finished,
  output logic                         sd_rd_req,
  output logic [31:0]                  sd_block_addr,
  input  logic [7:0]                   sd_dout,
  input  logic                         sd_valid,
  output logic                         blk_ready,
  input  logic                         blk_ack,
  output logic [15:0]                  blk_idx,
  input  logic [$clog2(BLK_BYTES)-1:0] rd_addr,
  output logic [7:0]                   rd_data
`ifdef BLK_CHECKSUM_EN
  ,
  output logic [15:0]                  blk_sum
`endif
);

  localparam int unsigned AW  = $clog2(BLK_BYTES);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  fetch_state_t   state_q, state_d;
  logic [AW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           sd_valid_q;
  logic [31:0]    start_blk_q, start_blk_d;
  logic [15:0]    num_blks_q, num_blks_d;
  logic           busy_d, done_d, error_d, sd_rd_req_d, blk_ready_d;
  logic [31:0]    sd_block_addr_d;
  logic [15:0]    blk_idx_d;
  logic           byte_edge_c;
  logic           wr_en_c;
`ifdef BLK_CHECKSUM_EN
  logic [15:0]    blk_sum_d;
`endif

  // A held sd_valid level counts once; only its rising edge marks a byte.
  assign byte_edge_c = sd_valid & ~sd_valid_q;
  assign wr_en_c     = (state_q == FILL) && byte_edge_c;

  sd_buf_ram #(
    .DEPTH (BLK_BYTES),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (byte_cnt_q),
    .wdata (sd_dout),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      wdog_q        <= '0;
      sd_valid_q    <= 1'b0;
      start_blk_q   <= '0;
      num_blks_q    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      sd_rd_req     <= 1'b0;
      sd_block_addr <= '0;
      blk_ready     <= 1'b0;
      blk_idx       <= '0;
`ifdef BLK_CHECKSUM_EN
      blk_sum       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      wdog_q        <= wdog_d;
      sd_valid_q    <= sd_valid;
      start_blk_q   <= start_blk_d;
      num_blks_q    <= num_blks_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
      sd_rd_req     <= sd_rd_req_d;
      sd_block_addr <= sd_block_addr_d;
      blk_ready     <= blk_ready_d;
      blk_idx       <= blk_idx_d;
`ifdef BLK_CHECKSUM_EN
      blk_sum       <= blk_sum_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    wdog_d          = wdog_q;
    start_blk_d     = start_blk_q;
    num_blks_d      = num_blks_q;
    busy_d          = busy;
    done_d          = 1'b0;
    error_d         = error;
    sd_rd_req_d     = 1'b0;
    sd_block_addr_d = sd_block_addr;
    blk_ready_d     = blk_ready;
    blk_idx_d       = blk_idx;
`ifdef BLK_CHECKSUM_EN
    blk_sum_d       = blk_sum;
    if (wr_en_c) blk_sum_d = blk_sum + 16'(sd_dout);
`endif

    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          start_blk_d = start_blk;
          num_blks_d  = num_blks;
          error_d     = 1'b0;
          blk_idx_d   = '0;
          if (num_blks == 16'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = WAIT_INIT;
          end
        end
      end

      WAIT_INIT: begin
        // Request is registered so it is high exactly while in REQ.
        if (sd_init_finished) begin
          sd_rd_req_d     = 1'b1;
          sd_block_addr_d = blk_addr(start_blk_q, blk_idx);
          state_d         = REQ;
`ifdef BLK_CHECKSUM_EN
          blk_sum_d       = '0;
`endif
        end
      end

      REQ: begin
        byte_cnt_d = '0;
        wdog_d     = '0;
        state_d    = FILL;
      end

      FILL: begin
        if (byte_edge_c) begin
          byte_cnt_d = byte_cnt_q + AW'(1);
          wdog_d     = '0;
          if (byte_cnt_q == AW'(BLK_BYTES - 1)) begin
            blk_ready_d = 1'b1;
            state_d     = READY;
          end
        end else if (wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
          // Controller stalled: abandon the run without a done pulse.
          error_d     = 1'b1;
          busy_d      = 1'b0;
          blk_ready_d = 1'b0;
          state_d     = IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      READY: begin
        if (blk_ack) begin
          blk_ready_d = 1'b0;
          if (blk_idx == num_blks_q - 16'd1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            blk_idx_d = blk_idx + 16'd1;
            state_d   = WAIT_INIT;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
